serial_command_controller: RTL and testbench
============================================

Name: serial_command_controller

Overview:
Word-serial successor to the packed-frame command controller. It assembles a command frame from a byte/word stream (i_data/i_dv, one word per strobe) and issues register-file write or read strobes. For reads, it waits for read data and serialises the response back out over a valid/ready word channel. Address width, value width, frame timeout and command codes are parametrised. The block sits between the UART/word receiver and the register file.

Parameters:
WORD_WIDTH, 8, width of one stream word
ADDR_WORDS, 1, address words per frame; address width AW = ADDR_WORDS*WORD_WIDTH
VALUE_WORDS, 4, value words per write/response; value width VW = VALUE_WORDS*WORD_WIDTH
TIMEOUT_CYCLES, 16, max idle cycles between words inside a frame; 0 disables the timeout
READ_CMD, 8'h00, read command code (WORD_WIDTH wide)
WRITE_CMD, 8'hAA, write command code (WORD_WIDTH wide)

Ports:
clk  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset (0 = reset)
i_data  in  WORD_WIDTH  incoming stream word
i_dv  in  1  i_data valid, single-cycle strobe per word
o_w_addr  out  AW  write address, held after the strobe
o_w_data  out  VW  write data, held after the strobe
o_w_en  out  1  write strobe, one cycle
o_r_addr  out  AW  read address, held after the strobe
o_r_en  out  1  read strobe, one cycle
i_r_data  in  VW  read data from the register file
i_r_valid  in  1  i_r_data valid
o_tx_data  out  WORD_WIDTH  response word
o_tx_dv  out  1  response word valid
i_tx_ready  in  1  downstream accepts the response word
o_busy  out  1  high in any state other than IDLE
o_err  out  1  one-cycle error pulse

Behaviour:
- Reset: clk and i_reset as named above; i_reset is asynchronous and active-low. While reset is asserted, all outputs are 0, the state is IDLE and all counters are 0.
- Frame format: CMD, then ADDR_WORDS address words (MSB word first). WRITE frames follow with VALUE_WORDS value words (MSB first). READ frames carry no value words.
- States: IDLE, ADDR, VALUE, EXEC_W, EXEC_R, WAIT_RD, TX.
- IDLE: on i_dv, compare the word.
  - == READ_CMD or WRITE_CMD -> ADDR.
  - Any other code -> o_err pulse next cycle; stay in IDLE.
- ADDR: each i_dv shifts a word into the address register. After the ADDR_WORDS-th word: WRITE -> VALUE; READ -> EXEC_R.
- VALUE: each i_dv shifts a word into the data register. After the VALUE_WORDS-th word -> EXEC_W.
- EXEC_W: o_w_en=1 for exactly one cycle, in the cycle after the last value word's edge. o_w_addr/o_w_data are valid that cycle and held until the next write. Next state IDLE.
- EXEC_R: o_r_en=1 for exactly one cycle, in the cycle after the last address word; o_r_addr is held. Next state WAIT_RD.
- WAIT_RD: i_r_valid is sampled from the o_r_en cycle onward, including that cycle. On i_r_valid, latch i_r_data -> TX. No timeout in this state.
- TX: emit VALUE_WORDS words, MSB first.
  - o_tx_dv held high with stable o_tx_data until an edge where i_tx_ready=1; then advance to the next word.
  - After the last word is accepted -> IDLE, o_tx_dv=0 the next cycle.
- Timeout: the counter clears on every accepted word and counts in ADDR/VALUE. Reaching TIMEOUT_CYCLES with no word -> IDLE plus an o_err pulse; the partial frame is discarded with no strobe.
- i_dv in EXEC_*/WAIT_RD/TX: the word is dropped and o_err pulses. The frame in progress is unaffected.
- Reset mid-frame or mid-TX: immediate abort. No strobe is issued and o_tx_dv drops asynchronously.
- o_err is never high for more than one consecutive cycle per event. Simultaneous error sources produce a single pulse.

Optional Feature:
CMD_CHECKSUM_EN.
- Defined: every frame ends with one extra word equal to the XOR of all preceding frame words. This adds a state CSUM, entered after the last ADDR (read) or VALUE (write) word; the timeout applies in CSUM.
  - Mismatch -> o_err pulse, IDLE, no strobe.
  - The TX response appends one trailing word: the XOR of the VALUE_WORDS response words.
- Undefined: no CSUM state, no trailing words, and the behaviour is exactly as above.

Test Plan:
- Write: words AA,21,87,65,43,21, one per 3 cycles -> o_w_en one cycle after the last word with o_w_addr=21 and o_w_data=87654321; o_err never asserts.
- Read with latency: 00,12, then i_r_valid 5 cycles after o_r_en with i_r_data=12345678 -> o_tx words 12,34,56,78; o_busy low after the last accept.
- Backpressure: during the read above, hold i_tx_ready=0 for 4 cycles on word 2 -> o_tx_data stays 34 with o_tx_dv high; no word is lost or duplicated.
- Bad command 55 -> one-cycle o_err, o_busy stays 0. Next, AA,21 followed by 20 idle cycles -> o_err at cycle 16 after 21, no o_w_en.
- Reset asserted between value words 2 and 3 of a write -> outputs 0 immediately. After release, a full write frame succeeds normally.
- With CMD_CHECKSUM_EN: AA,21,87,65,43,21,<correct XOR> -> write occurs; the same frame with the XOR word inverted -> o_err, no o_w_en.

Source files
------------

// File: rtl/serial_command_controller.sv
// Word-serial command frame decoder: issues register-file write/read strobes and serialises
// read responses over a valid/ready word channel. Define CMD_CHECKSUM_EN for frame XOR checking.
module serial_command_controller #(
    parameter int WORD_WIDTH     = 8,
    parameter int ADDR_WORDS     = 1,
    parameter int VALUE_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [WORD_WIDTH-1:0] READ_CMD  = '0,
    parameter logic [WORD_WIDTH-1:0] WRITE_CMD = WORD_WIDTH'(8'hAA)
) (
    input  logic                                clk,
    input  logic                                i_reset,
    input  logic [WORD_WIDTH-1:0]               i_data,
    input  logic                                i_dv,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0]    o_w_addr,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0]   o_w_data,
    output logic                                o_w_en,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0]    o_r_addr,
    output logic                                o_r_en,
    input  logic [VALUE_WORDS*WORD_WIDTH-1:0]   i_r_data,
    input  logic                                i_r_valid,
    output logic [WORD_WIDTH-1:0]               o_tx_data,
    output logic                                o_tx_dv,
    input  logic                                i_tx_ready,
    output logic                                o_busy,
    output logic                                o_err
);

    localparam int AW = ADDR_WORDS * WORD_WIDTH;
    localparam int VW = VALUE_WORDS * WORD_WIDTH;
`ifdef CMD_CHECKSUM_EN
    localparam int TX_WORDS = VALUE_WORDS + 1;
`else
    localparam int TX_WORDS = VALUE_WORDS;
`endif
    localparam int TXW       = TX_WORDS * WORD_WIDTH;
    localparam int MAX_WORDS = (ADDR_WORDS > TX_WORDS) ? ADDR_WORDS : TX_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LIMIT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE, ADDR, VALUE, EXEC_W, EXEC_R, WAIT_RD, TX
`ifdef CMD_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t                  state_reg;
    logic                    is_write_reg;
    logic [AW-1:0]           addr_reg;
    logic [VW-1:0]           value_reg;
    logic [CNT_W-1:0]        word_cnt_reg;
    logic [CNT_W-1:0]        tx_cnt_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [TXW-1:0]          tx_buf_reg;
`ifdef CMD_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]   csum_reg;
`endif

    logic [AW-1:0]           addr_shift;
    logic [VW-1:0]           value_shift;
    logic [TXW-1:0]          tx_load;
    logic                    in_frame;
    logic                    timeout_hit;
    logic                    is_cmd;

    assign addr_shift  = (addr_reg << WORD_WIDTH) | AW'(i_data);
    assign value_shift = (value_reg << WORD_WIDTH) | VW'(i_data);
    assign is_cmd      = (i_data == READ_CMD) || (i_data == WRITE_CMD);
    assign o_busy      = (state_reg != IDLE);

`ifdef CMD_CHECKSUM_EN
    // Response checksum: XOR of all response words, appended after the last data word.
    logic [WORD_WIDTH-1:0] r_words [VALUE_WORDS];
    logic [WORD_WIDTH-1:0] r_xor;

    generate
        for (genvar gi = 0; gi < VALUE_WORDS; gi++) begin : g_rwords
            assign r_words[gi] = i_r_data[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    always_comb begin
        r_xor = '0;
        for (int i = 0; i < VALUE_WORDS; i++) begin
            r_xor = r_xor ^ r_words[i];
        end
    end

    assign tx_load  = {i_r_data, r_xor};
    assign in_frame = (state_reg == ADDR) || (state_reg == VALUE) || (state_reg == CSUM);
`else
    assign tx_load  = i_r_data;
    assign in_frame = (state_reg == ADDR) || (state_reg == VALUE);
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !i_dv
                         && (to_cnt_reg == TO_W'(TO_LIMIT));

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            is_write_reg <= 1'b0;
            addr_reg     <= '0;
            value_reg    <= '0;
            word_cnt_reg <= '0;
            tx_cnt_reg   <= '0;
            to_cnt_reg   <= '0;
            tx_buf_reg   <= '0;
`ifdef CMD_CHECKSUM_EN
            csum_reg     <= '0;
`endif
            o_w_addr     <= '0;
            o_w_data     <= '0;
            o_w_en       <= 1'b0;
            o_r_addr     <= '0;
            o_r_en       <= 1'b0;
            o_tx_data    <= '0;
            o_tx_dv      <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_w_en <= 1'b0;
            o_r_en <= 1'b0;
            o_err  <= 1'b0;

            // Idle-gap counter: any accepted word or leaving the frame states clears it.
            if (in_frame && !i_dv && !timeout_hit && (TIMEOUT_CYCLES != 0))
                to_cnt_reg <= to_cnt_reg + 1'b1;
            else
                to_cnt_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (i_dv) begin
                        if (is_cmd) begin
                            state_reg    <= ADDR;
                            is_write_reg <= (i_data == WRITE_CMD);
                            word_cnt_reg <= '0;
`ifdef CMD_CHECKSUM_EN
                            csum_reg     <= i_data;
`endif
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (timeout_hit) begin
                        state_reg <= IDLE;
                        o_err     <= 1'b1;
                    end else if (i_dv) begin
                        addr_reg <= addr_shift;
`ifdef CMD_CHECKSUM_EN
                        csum_reg <= csum_reg ^ i_data;
`endif
                        if (word_cnt_reg == CNT_W'(ADDR_WORDS - 1)) begin
                            word_cnt_reg <= '0;
                            if (is_write_reg) begin
                                state_reg <= VALUE;
                            end else begin
`ifdef CMD_CHECKSUM_EN
                                state_reg <= CSUM;
`else
                                state_reg <= EXEC_R;
                                o_r_en    <= 1'b1;
                                o_r_addr  <= addr_shift;
`endif
                            end
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                        end
                    end
                end

                VALUE: begin
                    if (timeout_hit) begin
                        state_reg <= IDLE;
                        o_err     <= 1'b1;
                    end else if (i_dv) begin
                        value_reg <= value_shift;
`ifdef CMD_CHECKSUM_EN
                        csum_reg  <= csum_reg ^ i_data;
`endif
                        if (word_cnt_reg == CNT_W'(VALUE_WORDS - 1)) begin
                            word_cnt_reg <= '0;
`ifdef CMD_CHECKSUM_EN
                            state_reg    <= CSUM;
`else
                            state_reg    <= EXEC_W;
                            o_w_en       <= 1'b1;
                            o_w_addr     <= addr_reg;
                            o_w_data     <= value_shift;
`endif
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                        end
                    end
                end

`ifdef CMD_CHECKSUM_EN
                CSUM: begin
                    if (timeout_hit) begin
                        state_reg <= IDLE;
                        o_err     <= 1'b1;
                    end else if (i_dv) begin
                        if (i_data != csum_reg) begin
                            state_reg <= IDLE;
                            o_err     <= 1'b1;
                        end else if (is_write_reg) begin
                            state_reg <= EXEC_W;
                            o_w_en    <= 1'b1;
                            o_w_addr  <= addr_reg;
                            o_w_data  <= value_reg;
                        end else begin
                            state_reg <= EXEC_R;
                            o_r_en    <= 1'b1;
                            o_r_addr  <= addr_reg;
                        end
                    end
                end
`endif

                EXEC_W: begin
                    if (i_dv)
                        o_err <= 1'b1;
                    state_reg <= IDLE;
                end

                // Read data may already be valid in the strobe cycle itself.
                EXEC_R, WAIT_RD: begin
                    if (i_dv)
                        o_err <= 1'b1;
                    if (i_r_valid) begin
                        state_reg  <= TX;
                        o_tx_dv    <= 1'b1;
                        o_tx_data  <= tx_load[TXW-1 -: WORD_WIDTH];
                        tx_buf_reg <= tx_load << WORD_WIDTH;
                        tx_cnt_reg <= '0;
                    end else begin
                        state_reg  <= WAIT_RD;
                    end
                end

                TX: begin
                    if (i_dv)
                        o_err <= 1'b1;
                    if (i_tx_ready) begin
                        if (tx_cnt_reg == CNT_W'(TX_WORDS - 1)) begin
                            state_reg  <= IDLE;
                            o_tx_dv    <= 1'b0;
                            o_tx_data  <= '0;
                            tx_cnt_reg <= '0;
                        end else begin
                            tx_cnt_reg <= tx_cnt_reg + 1'b1;
                            o_tx_data  <= tx_buf_reg[TXW-1 -: WORD_WIDTH];
                            tx_buf_reg <= tx_buf_reg << WORD_WIDTH;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    o_tx_dv   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_command_controller.sv
// Directed bench for serial_command_controller: write, read with latency and backpressure,
// bad command, frame timeout, mid-frame reset and (with CMD_CHECKSUM_EN) checksum framing.
module tb_serial_command_controller;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_dv = 1'b0;
    logic [7:0]  o_w_addr;
    logic [31:0] o_w_data;
    logic        o_w_en;
    logic [7:0]  o_r_addr;
    logic        o_r_en;
    logic [31:0] i_r_data = '0;
    logic        i_r_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_dv;
    logic        i_tx_ready = 1'b0;
    logic        o_busy;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int wen_pulses = 0;
    int e0, w0;
    logic [7:0] fxor;
    logic [7:0] tx_q[$];

    serial_command_controller dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .i_dv       (i_dv),
        .o_w_addr   (o_w_addr),
        .o_w_data   (o_w_data),
        .o_w_en     (o_w_en),
        .o_r_addr   (o_r_addr),
        .o_r_en     (o_r_en),
        .i_r_data   (i_r_data),
        .i_r_valid  (i_r_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_dv    (o_tx_dv),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: pulse counters and the words the next edge will accept.
    always @(negedge clk) begin
        if (o_err) err_pulses++;
        if (o_w_en) wen_pulses++;
        if (o_tx_dv && i_tx_ready && i_reset) tx_q.push_back(o_tx_data);
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task send(input logic [7:0] w, input int gap);
        i_data = w;
        i_dv   = 1'b1;
        fxor   = fxor ^ w;
        tick;
        i_dv   = 1'b0;
        i_data = '0;
        repeat (gap) tick;
    endtask

    task end_frame;
`ifdef CMD_CHECKSUM_EN
        send(fxor, 0);
`endif
    endtask

    task drain(input int budget);
        int n;
        n = 0;
        i_tx_ready = 1'b1;
        while (o_tx_dv && n < budget) begin
            tick;
            n++;
        end
        chk("tx_drain_done", o_tx_dv, 1'b0);
        i_tx_ready = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] v);
        logic [7:0] exp_w[$];
        for (int i = 3; i >= 0; i--) exp_w.push_back(v[i*8 +: 8]);
`ifdef CMD_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = '0;
            for (int i = 0; i < 4; i++) x = x ^ v[i*8 +: 8];
            exp_w.push_back(x);
        end
`endif
        chk({tag, "_count"}, 64'(tx_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < tx_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), tx_q[i], exp_w[i]);
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fxor = '0;
        repeat (3) tick;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_strobes", {o_w_en, o_r_en, o_tx_dv, o_err}, 4'b0);
        chk("rst_waddr", o_w_addr, 8'h00);
        chk("rst_wdata", o_w_data, 32'h0);
        chk("rst_txdata", o_tx_data, 8'h00);
        i_reset = 1'b1;
        tick;

        // Write frame, one word every 3 cycles
        e0 = err_pulses;
        fxor = '0;
        send(8'hAA, 2); send(8'h21, 2); send(8'h87, 2);
        send(8'h65, 2); send(8'h43, 2); send(8'h21, 0);
        end_frame();
        chk("wr_wen", o_w_en, 1'b1);
        chk("wr_addr", o_w_addr, 8'h21);
        chk("wr_data", o_w_data, 32'h87654321);
        tick;
        chk("wr_wen_off", o_w_en, 1'b0);
        chk("wr_busy_off", o_busy, 1'b0);
        chk("wr_data_held", o_w_data, 32'h87654321);
        chk("wr_no_err", 64'(err_pulses - e0), 64'd0);

        // Read with 5-cycle latency and backpressure on word 2
        fxor = '0;
        send(8'h00, 1); send(8'h12, 0);
        end_frame();
        chk("rd_ren", o_r_en, 1'b1);
        chk("rd_raddr", o_r_addr, 8'h12);
        tick;
        chk("rd_ren_off", o_r_en, 1'b0);
        chk("rd_wait_busy", o_busy, 1'b1);
        repeat (4) tick;
        i_r_valid = 1'b1; i_r_data = 32'h12345678; i_tx_ready = 1'b0;
        tick;
        i_r_valid = 1'b0; i_r_data = '0;
        chk("rd_tx0", {o_tx_dv, o_tx_data}, {1'b1, 8'h12});
        i_tx_ready = 1'b1;
        tick;
        chk("bp_word2", o_tx_data, 8'h34);
        i_tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("bp_hold%0d", k), {o_tx_dv, o_tx_data}, {1'b1, 8'h34});
        end
        drain(20);
        chk("rd_busy_off", o_busy, 1'b0);
        chk("rd_raddr_held", o_r_addr, 8'h12);
        check_resp("rd", 32'h12345678);

        // Read data valid in the strobe cycle; stray word during TX is dropped
        fxor = '0;
        send(8'h00, 1); send(8'h34, 0);
        end_frame();
        chk("rd0_ren", o_r_en, 1'b1);
        i_r_valid = 1'b1; i_r_data = 32'hA1B2C3D4; i_tx_ready = 1'b1;
        tick;
        i_r_valid = 1'b0; i_r_data = '0;
        chk("rd0_tx0", {o_tx_dv, o_tx_data}, {1'b1, 8'hA1});
        tick;
        e0 = err_pulses;
        i_dv = 1'b1; i_data = 8'hAA;
        tick;
        i_dv = 1'b0; i_data = '0;
        chk("tx_drop_err", o_err, 1'b1);
        chk("tx_drop_busy", o_busy, 1'b1);
        drain(20);
        check_resp("rd0", 32'hA1B2C3D4);
        chk("tx_drop_one_pulse", 64'(err_pulses - e0), 64'd1);

        // Bad command
        e0 = err_pulses;
        send(8'h55, 0);
        chk("bad_err", o_err, 1'b1);
        chk("bad_busy", o_busy, 1'b0);
        tick;
        chk("bad_err_off", o_err, 1'b0);
        chk("bad_single", 64'(err_pulses - e0), 64'd1);

        // Timeout after AA,21 with no further words
        w0 = wen_pulses;
        fxor = '0;
        send(8'hAA, 0); send(8'h21, 0);
        for (int k = 1; k <= 20; k++) begin
            tick;
            chk($sformatf("to_err_c%0d", k), o_err, 64'(k == 16));
        end
        chk("to_no_wen", 64'(wen_pulses - w0), 64'd0);
        chk("to_idle", o_busy, 1'b0);

        // Reset between value words 2 and 3, then a clean write
        fxor = '0;
        send(8'hAA, 1); send(8'h21, 1); send(8'h87, 1); send(8'h65, 1);
        chk("mid_busy", o_busy, 1'b1);
        #2 i_reset = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_waddr", o_w_addr, 8'h00);
        chk("mid_rst_wdata", o_w_data, 32'h0);
        tick; tick;
        i_reset = 1'b1;
        tick;
        w0 = wen_pulses;
        fxor = '0;
        send(8'hAA, 1); send(8'h05, 1); send(8'hDE, 1);
        send(8'hAD, 1); send(8'hBE, 1); send(8'hEF, 0);
        end_frame();
        chk("rec_wen", o_w_en, 1'b1);
        chk("rec_addr", o_w_addr, 8'h05);
        chk("rec_data", o_w_data, 32'hDEADBEEF);
        tick;
        chk("rec_single_wen", 64'(wen_pulses - w0), 64'd1);

`ifdef CMD_CHECKSUM_EN
        // Inverted checksum word: error, no write
        e0 = err_pulses;
        w0 = wen_pulses;
        fxor = '0;
        send(8'hAA, 0); send(8'h21, 0); send(8'h87, 0);
        send(8'h65, 0); send(8'h43, 0); send(8'h21, 0);
        chk("cs_expected_xor", fxor, 8'h0B);
        send(~fxor, 0);
        chk("cs_bad_err", o_err, 1'b1);
        chk("cs_bad_nowen", o_w_en, 1'b0);
        tick;
        chk("cs_bad_idle", o_busy, 1'b0);
        chk("cs_bad_wen_cnt", 64'(wen_pulses - w0), 64'd0);
        chk("cs_bad_err_cnt", 64'(err_pulses - e0), 64'd1);
`endif

        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
